// File: rtl/gpr_arbiter_if.sv
// Requester, register-file and shared-bus signals of the GPR arbiter.
// The arbiter uses the slave modport; the requesters/register-file side uses master.
interface gpr_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic                     c_halt;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_write;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_wdata;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [ADDR_W-1:0]        regaddr;
  logic                     c_regwrite;
  logic                     c_regread;
  logic                     bus_drive;
  logic [DATA_W-1:0]        bus_wdata;
  logic [DATA_W-1:0]        bus_rdata;
  logic                     busy;

  modport slave (
    input  c_halt, req_valid, req_write, req_addr, req_wdata, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, regaddr, c_regwrite, c_regread,
           bus_drive, bus_wdata, busy
  );

  modport master (
    output c_halt, req_valid, req_write, req_addr, req_wdata, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, regaddr, c_regwrite, c_regread,
           bus_drive, bus_wdata, busy
  );
endinterface

// File: rtl/gpr_arbiter.sv
// Round-robin arbiter sharing the 16x8 register file and its 8-bit bus.
// One transaction at a time: write takes 2 cycles, read 3 (IDLE, READ, RESP).
module gpr_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          reset,
  gpr_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [ADDR_W-1:0]   regaddr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic                c_regwrite_q;
  logic                c_regread_q;
  logic                bus_drive_q;
  logic                busy_q;

  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_found;
  logic                accept;

  // First valid requester after the last grant, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before the search, otherwise a latch is inferred.
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k >= NREQ) ? IDX_W'(int'(rr_ptr_q) + k - NREQ)
                                          : IDX_W'(int'(rr_ptr_q) + k);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept        = reset && (state_q == IDLE) && !bus.c_halt && gnt_found;
  assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NREQ - 1);
      gnt_q        <= '0;
      regaddr_q    <= '0;
      bus_wdata_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_valid_q  <= '0;
      c_regwrite_q <= 1'b0;
      c_regread_q  <= 1'b0;
      bus_drive_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q     <= gnt_idx;
            rr_ptr_q  <= gnt_idx;
            regaddr_q <= bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            busy_q    <= 1'b1;
            if (bus.req_write[gnt_idx]) begin
              state_q      <= WRITE;
              c_regwrite_q <= 1'b1;
              bus_drive_q  <= 1'b1;
              bus_wdata_q  <= bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            end else begin
              state_q     <= READ;
              c_regread_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          state_q      <= IDLE;
          c_regwrite_q <= 1'b0;
          bus_drive_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
        READ: begin
          state_q     <= RESP;
          c_regread_q <= 1'b0;
          rsp_rdata_q <= bus.bus_rdata;
          rsp_valid_q <= NREQ'(1) << gnt_q;
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.regaddr    = regaddr_q;
  assign bus.c_regwrite = c_regwrite_q;
  assign bus.c_regread  = c_regread_q;
  assign bus.bus_drive  = bus_drive_q;
  assign bus.bus_wdata  = bus_wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/gpr_arbiter.md
Name: gpr_arbiter

Overview:
- Shares the 16x8 general-purpose register file between NREQ requesters (e.g. ALU writeback, operand fetch, I/O unit).
- Grants requesters round-robin and drives the register file controls: regaddr, c_regwrite, c_regread.
- Sequences the shared 8-bit bus: drives write data onto it, and captures read data from it.
- Returns read data to the granted requester with a one-cycle valid pulse.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 4, register address width.
- DATA_W, 8, register/bus data width.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset.
- c_halt  input  1  when 1, no new grant issued; in-flight transaction completes.
- req_valid  input  NREQ  per-requester request; held until matching req_ready.
- req_write  input  NREQ  1 = write, 0 = read; stable while req_valid.
- req_addr  input  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NREQ*DATA_W  packed write data, same packing.
- req_ready  output  NREQ  one-hot accept pulse.
- rsp_valid  output  NREQ  one-hot read-data-valid pulse.
- rsp_rdata  output  DATA_W  read data; valid while rsp_valid nonzero, holds last value otherwise.
- regaddr  output  ADDR_W  register file address.
- c_regwrite  output  1  register file write strobe.
- c_regread  output  1  register file read enable (register file drives bus).
- bus_drive  output  1  enable for bus_wdata onto the shared bus.
- bus_wdata  output  DATA_W  write data for the bus.
- bus_rdata  input  DATA_W  shared bus value.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 has highest priority first.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, regaddr, c_regwrite, c_regread, bus_drive, bus_wdata, busy.
  - An in-flight write or read is aborted; no partial response is issued.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - If c_halt=0 and any req_valid: grant g = first set req_valid searching from rr_ptr+1 upward, with modulo-NREQ wrap.
  - req_ready[g]=1 combinationally in that cycle. It is the only combinational output.
  - At the edge: latch g, addr, wdata, write; set rr_ptr=g; next state WRITE if write else READ.
  - No request or c_halt=1: remain in IDLE, req_ready=0.
- WRITE (1 cycle): regaddr=latched addr, c_regwrite=1, bus_drive=1, bus_wdata=latched data; then IDLE. The register file captures at the end of this cycle.
- READ (1 cycle): regaddr=latched addr, c_regread=1, bus_drive=0; rsp_rdata<=bus_rdata at the edge; then RESP.
- RESP (1 cycle): rsp_valid[g]=1, rsp_rdata stable; then IDLE.
- Outputs regaddr, c_regwrite, c_regread, bus_drive, bus_wdata, rsp_valid and busy come only from flops; no req-to-output combinational path.
- c_regwrite and c_regread are never both 1; bus_drive=1 only in WRITE.
- Latency (accept cycle t):
  - Write committed at end of t+1.
  - Read data is the register value at t+1, with rsp_valid at t+2.
  - Throughput: 2 cycles per write, 3 per read.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0.
- A requester dropping req_valid before req_ready is legal and is simply not granted.
- c_halt asserted during WRITE, READ or RESP does not affect that transaction.
- Read-after-write to the same address by consecutive grants returns the new data.
- Address 0 is not special-cased here.

Test Plan:
- Reset release, req0 write addr 3 data 0xA5 -> req_ready[0] in cycle 1, c_regwrite=1 with regaddr=3 and bus_wdata=0xA5 in cycle 2, busy back to 0 in cycle 3.
- req1 read addr 3 after the previous write -> c_regread=1 at t+1; rsp_valid=3'b010 and rsp_rdata=0xA5 at t+2; exactly one pulse.
- All three requesters valid continuously, reads only -> grant order 0,1,2,0,1,2, each 3 cycles apart; no requester is granted twice consecutively.
- c_halt=1 with req2 valid -> no req_ready for 10 cycles. Deassert c_halt -> req_ready[2] the same cycle.
- Assert reset in READ state -> all outputs 0 immediately with no clock edge, no rsp_valid. After release, a pending req0 is granted first.
- Write addr 7 data 0x3C by req2, then read addr 7 by req0 back-to-back -> rsp_rdata=0x3C; c_regwrite and c_regread are never high together.
